// File: rtl/dmem_pkg.sv
// Shared sizing and dump-sequencer state type for the LEGv8 data memory.
package dmem_pkg;

    localparam int N     = 64;
    localparam int DEPTH = 32;
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } dump_state_t;

endpackage

// File: rtl/dmem_dump_fsm.sv
// Dump sequencer: edge-detects dump, walks every word index and
// hands beats out over a valid/ready port.
module dmem_dump_fsm
    import dmem_pkg::*;
#(
    parameter int DEPTH = dmem_pkg::DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     dump,
    input  logic                     dump_ready,
    output logic [$clog2(DEPTH)-1:0] idx,
    output logic                     dump_valid,
    output logic                     dump_busy,
    output logic                     dump_done
);

    localparam int IW = $clog2(DEPTH);
    localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);

    dump_state_t   state;
    dump_state_t   state_nxt;
    logic [IW-1:0] idx_nxt;
    logic          dump_q;
    logic          start;
    logic          fire;

    assign start = dump & ~dump_q;
    assign fire  = dump_valid & dump_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            idx    <= '0;
            dump_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            idx    <= idx_nxt;
            dump_q <= dump;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SCAN;
                    idx_nxt   = '0;
                end
            end
            SCAN: begin
                // idx stays on the last word in DONE
                if (fire) begin
                    if (idx == LAST) begin
                        state_nxt = DONE;
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end
            end
            DONE: begin
                if (!dump) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign dump_valid = (state == SCAN);
    assign dump_busy  = (state == SCAN);
    assign dump_done  = (state == DONE);

endmodule

// File: rtl/data_memory_dump.sv
// Word-addressed LEGv8 data memory with an end-of-run dump port.
// Define DMEM_ALIGN_CHECK_EN to reject misaligned accesses and add misalign.
module data_memory_dump
    import dmem_pkg::*;
#(
    parameter int N     = dmem_pkg::N,
    parameter int DEPTH = dmem_pkg::DEPTH
) (
    input  logic         CLOCK_50,
    input  logic         reset,
    input  logic         memWrite,
    input  logic         memRead,
    input  logic [N-1:0] address,
    input  logic [N-1:0] writeData,
    output logic [N-1:0] readData,
    input  logic         dump,
    output logic         dump_valid,
    input  logic         dump_ready,
    output logic [N-1:0] dump_addr,
    output logic [N-1:0] dump_data,
    output logic         dump_busy,
    output logic         dump_done
`ifdef DMEM_ALIGN_CHECK_EN
    ,
    output logic         misalign
`endif
);

    localparam int IW = $clog2(DEPTH);

    logic [N-1:0]  mem [DEPTH];
    logic [IW-1:0] idx;
    logic [IW-1:0] dump_idx;
    logic          in_range;
    logic          aligned;
    logic          wr_en;
    logic          rd_en;

    assign idx      = address[IW+2:3];
    assign in_range = ~|address[N-1:IW+3];

`ifdef DMEM_ALIGN_CHECK_EN
    logic access;

    assign access  = memWrite | memRead;
    assign aligned = (address[2:0] == 3'b000);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            misalign <= 1'b0;
        end else if (access && !aligned) begin
            misalign <= 1'b1;
        end
    end
`else
    // Byte offset is don't-care: accesses hit the containing word
    logic unused_lsb;

    assign aligned    = 1'b1;
    assign unused_lsb = ^address[2:0];
`endif

    assign wr_en = memWrite & in_range & aligned;
    assign rd_en = memRead & in_range & aligned;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[idx] <= writeData;
        end
    end

    assign readData = (rd_en && !reset) ? mem[idx] : '0;

    dmem_dump_fsm #(
        .DEPTH(DEPTH)
    ) u_fsm (
        .clk       (CLOCK_50),
        .reset     (reset),
        .dump      (dump),
        .dump_ready(dump_ready),
        .idx       (dump_idx),
        .dump_valid(dump_valid),
        .dump_busy (dump_busy),
        .dump_done (dump_done)
    );

    // Beat data is the live word, so core stores during a stall show up
    assign dump_addr = reset ? '0 : {{(N-IW-3){1'b0}}, dump_idx, 3'b000};
    assign dump_data = reset ? '0 : mem[dump_idx];

endmodule

// File: tb/tb_data_memory_dump.sv
// Self-checking bench for data_memory_dump: vector table, dump sequences
// and random core traffic against an array model of the memory.
module tb_data_memory_dump;

    localparam int DEPTH = 32;

    logic        CLOCK_50 = 1'b0;
    logic        reset;
    logic        memWrite;
    logic        memRead;
    logic [63:0] address;
    logic [63:0] writeData;
    logic [63:0] readData;
    logic        dump;
    logic        dump_valid;
    logic        dump_ready;
    logic [63:0] dump_addr;
    logic [63:0] dump_data;
    logic        dump_busy;
    logic        dump_done;
`ifdef DMEM_ALIGN_CHECK_EN
    logic        misalign;
`endif

    int nvec = 0;
    int nmis = 0;

    logic [63:0] model [DEPTH];

    typedef struct {
        logic        we;
        logic        re;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] exp;
    } vec_t;

    vec_t tbl [12];

    data_memory_dump dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .memWrite  (memWrite),
        .memRead   (memRead),
        .address   (address),
        .writeData (writeData),
        .readData  (readData),
        .dump      (dump),
        .dump_valid(dump_valid),
        .dump_ready(dump_ready),
        .dump_addr (dump_addr),
        .dump_data (dump_data),
        .dump_busy (dump_busy),
        .dump_done (dump_done)
`ifdef DMEM_ALIGN_CHECK_EN
        ,
        .misalign  (misalign)
`endif
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Access is honoured only below DEPTH*8 and, with the check, aligned
    function automatic bit ok(input logic [63:0] a);
        bit r;
        r = (a < 64'(DEPTH * 8));
`ifdef DMEM_ALIGN_CHECK_EN
        r = r && (a[2:0] == 3'b000);
`endif
        return r;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    endtask

    task automatic do_dump(input int stall_beat, input int retrig_beat,
                           input int wr_beat, input int abort_beat);
        int k;
        int stalled;
        int cyc;
        k = 0;
        stalled = 0;
        cyc = 0;
        dump = 1'b1;
        dump_ready = 1'b1;
        step();
        chk("first_valid", 64'(dump_valid), 64'd1);
        while (k < DEPTH && cyc < 400) begin
            cyc++;
            if (k == abort_beat) break;
            dump_ready = !(k == stall_beat && stalled < 4);
            memWrite = 1'b0;
            if (retrig_beat >= 0 && k == 2) dump = 1'b0;
            if (k == retrig_beat) dump = 1'b1;
            if (k == stall_beat && stalled == 2) begin
                memWrite  = 1'b1;
                address   = 64'(k * 8);
                writeData = 64'hBEEF_0000 + 64'(k);
            end
            if (k == wr_beat && dump_ready) begin
                memWrite  = 1'b1;
                address   = 64'(k * 8);
                writeData = 64'hCAFE_0000 + 64'(k);
            end
            #1;
            chk("beat_valid", 64'(dump_valid), 64'd1);
            chk("beat_busy", 64'(dump_busy), 64'd1);
            chk("beat_addr", dump_addr, 64'(k * 8));
            chk("beat_data", dump_data, model[k]);
            if (memWrite) model[address[7:3]] = writeData;
            if (dump_valid && dump_ready) k++;
            else if (!dump_ready) stalled++;
            @(posedge CLOCK_50);
            #1;
        end
        memWrite = 1'b0;
        if (abort_beat < 0) chk("beat_count", 64'(k), 64'(DEPTH));
        else chk("abort_reach", 64'(k), 64'(abort_beat));
    endtask

    task automatic finish_dump();
        chk("done_set", 64'(dump_done), 64'd1);
        chk("valid_clr", 64'(dump_valid), 64'd0);
        chk("busy_clr", 64'(dump_busy), 64'd0);
        repeat (2) begin
            step();
            chk("done_hold", 64'(dump_done), 64'd1);
        end
        dump = 1'b0;
        step();
        chk("done_clr", 64'(dump_done), 64'd0);
        chk("idle_valid", 64'(dump_valid), 64'd0);
    endtask

    logic [63:0] a;
    logic [63:0] exp;
    int          r;

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 64'h18, 64'hAB, 64'h0};
        tbl[1]  = '{1'b0, 1'b1, 64'h18, 64'h0, 64'hAB};
        tbl[2]  = '{1'b0, 1'b1, 64'h20, 64'h0, 64'h0};
        tbl[3]  = '{1'b1, 1'b1, 64'h100, 64'hDEAD, 64'h0};
        tbl[4]  = '{1'b0, 1'b1, 64'h0, 64'h0, 64'h0};
        tbl[5]  = '{1'b1, 1'b1, 64'hF8, 64'h1234, 64'h0};
        tbl[6]  = '{1'b0, 1'b1, 64'hF8, 64'h0, 64'h1234};
        tbl[7]  = '{1'b0, 1'b0, 64'hF8, 64'h0, 64'h0};
        tbl[8]  = '{1'b1, 1'b1, 64'h18, 64'hCD, 64'hAB};
        tbl[9]  = '{1'b0, 1'b1, 64'h18, 64'h0, 64'hCD};
        tbl[10] = '{1'b0, 1'b1, 64'h1_0000_0018, 64'h0, 64'h0};
        tbl[11] = '{1'b0, 1'b1, 64'h100, 64'h0, 64'h0};

        reset = 1'b1;
        memWrite = 1'b0;
        memRead = 1'b0;
        address = '0;
        writeData = '0;
        dump = 1'b0;
        dump_ready = 1'b0;
        clear_model();
        step();
        step();
        reset = 1'b0;
        memRead = 1'b1;
        #1;
        chk("rst_valid", 64'(dump_valid), 64'd0);
        chk("rst_busy", 64'(dump_busy), 64'd0);
        chk("rst_done", 64'(dump_done), 64'd0);
        chk("rst_rdata", readData, 64'd0);
        chk("rst_daddr", dump_addr, 64'd0);
        chk("rst_ddata", dump_data, 64'd0);
`ifdef DMEM_ALIGN_CHECK_EN
        chk("rst_misalign", 64'(misalign), 64'd0);
`endif
        step();

        for (int i = 0; i < 12; i++) begin
            memWrite  = tbl[i].we;
            memRead   = tbl[i].re;
            address   = tbl[i].addr;
            writeData = tbl[i].wdata;
            #1;
            chk("tbl_rd", readData, tbl[i].exp);
            if (tbl[i].we && ok(tbl[i].addr)) model[tbl[i].addr[7:3]] = tbl[i].wdata;
            step();
        end

        memWrite = 1'b1;
        memRead = 1'b0;
        address = 64'h18;
        writeData = 64'h55;
        model[3] = 64'h55;
        step();
        memWrite = 1'b0;

        do_dump(-1, -1, -1, -1);
        finish_dump();

        do_dump(5, 8, 7, -1);
        finish_dump();

`ifdef DMEM_ALIGN_CHECK_EN
        memWrite = 1'b1;
        address = 64'h0C;
        writeData = 64'h11;
        step();
        memWrite = 1'b0;
        memRead = 1'b1;
        address = 64'h08;
        #1;
        chk("mis_word1", readData, model[1]);
        chk("mis_set", 64'(misalign), 64'd1);
        memWrite = 1'b1;
        writeData = 64'h22;
        step();
        model[1] = 64'h22;
        memWrite = 1'b0;
        #1;
        chk("mis_aligned_wr", readData, 64'h22);
        chk("mis_sticky", 64'(misalign), 64'd1);
`endif

        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 9);
            if (r == 0) a = 64'($urandom_range(32, 63) * 8);
            else if (r == 1) a = {$urandom, $urandom};
            else if (r == 2) a = 64'($urandom_range(0, 255));
            else a = 64'($urandom_range(0, 31) * 8);
            memWrite  = 1'($urandom_range(0, 1));
            memRead   = 1'($urandom_range(0, 1));
            address   = a;
            writeData = {$urandom, $urandom};
            #1;
            exp = (memRead && ok(a)) ? model[a[7:3]] : 64'd0;
            chk("rand_rd", readData, exp);
            if (memWrite && ok(a)) model[a[7:3]] = writeData;
            step();
        end
        memWrite = 1'b0;
        memRead = 1'b0;

        do_dump(-1, -1, -1, -1);
        finish_dump();

        do_dump(-1, -1, -1, 10);
        reset = 1'b1;
        dump = 1'b0;
        memRead = 1'b1;
        address = 64'h18;
        step();
        chk("abort_valid", 64'(dump_valid), 64'd0);
        chk("abort_busy", 64'(dump_busy), 64'd0);
        chk("abort_done", 64'(dump_done), 64'd0);
        reset = 1'b0;
        clear_model();
        #1;
        chk("abort_rdata", readData, 64'd0);
`ifdef DMEM_ALIGN_CHECK_EN
        chk("abort_misalign", 64'(misalign), 64'd0);
`endif
        memRead = 1'b0;
        step();
        chk("abort_no_beat", 64'(dump_valid), 64'd0);

        do_dump(-1, -1, -1, -1);
        finish_dump();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
